// File: rtl/down_counter_arbiter.sv
// down_counter_arbiter: one shared WIDTH-bit down-counter, time-shared round-robin among NREQ requesters.
// Build option DCA_AUTORELOAD_EN: a sole remaining requester reloads directly from DONE (periodic timer).
module down_counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  CDN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] LDVAL,
  input  logic                  EN,
  output logic [NREQ-1:0]       GNT,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      CNT,
  output logic                  TC,
  output logic [NREQ-1:0]       DONE,
  output logic                  ABRT
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    win_idx, cand;
  logic             win_found;
  logic             req_g;
  logic [WIDTH-1:0] ld_g;
  logic [NREQ-1:0]  gnt_n, done_n;
  logic [WIDTH-1:0] cnt_n;
  logic             abrt_n;

  // Handshake: a requester raises REQ (level) and holds it until its DONE pulse.
  // GNT marks ownership from LOAD through DONE; dropping REQ while owning (LOAD/COUNT)
  // cancels the operation with an ABRT pulse instead of DONE.

  // Round-robin search starts just after the last winner; ptr also names the current owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_g = REQ[ptr];
  assign ld_g  = LDVAL[int'(ptr)*WIDTH +: WIDTH];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = GNT;
    cnt_n   = CNT;
    done_n  = '0;
    abrt_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          gnt_n   = NREQ'(1) << win_idx;
          ptr_n   = win_idx;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!req_g) begin
          abrt_n  = 1'b1;
          gnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n   = ld_g;
          state_n = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Withdrawal wins even at terminal count; zero never decrements, so no wrap.
        if (!req_g) begin
          abrt_n  = 1'b1;
          gnt_n   = '0;
          state_n = ST_IDLE;
        end else if (CNT == '0) begin
          done_n  = GNT;
          state_n = ST_DONE;
        end else if (EN) begin
          cnt_n = CNT - WIDTH'(1);
        end
      end
      ST_DONE: begin
`ifdef DCA_AUTORELOAD_EN
        if (req_g && ((REQ & ~GNT) == '0)) begin
          state_n = ST_LOAD;
        end else begin
          gnt_n   = '0;
          state_n = ST_IDLE;
        end
`else
        gnt_n   = '0;
        state_n = ST_IDLE;
`endif
      end
      default: begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CDN) begin
      state <= ST_IDLE;
      ptr   <= PW'(NREQ - 1);
      GNT   <= '0;
      CNT   <= '0;
      DONE  <= '0;
      ABRT  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      GNT   <= gnt_n;
      CNT   <= cnt_n;
      DONE  <= done_n;
      ABRT  <= abrt_n;
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign TC   = (state == ST_COUNT) && (CNT == '0);

endmodule

// File: tb/tb_down_counter_arbiter.sv
// Bench for down_counter_arbiter: per-step schedules of inputs and expected outputs built from a
// transaction-level model (grant order, load latency, enabled-cycle counting), then replayed on the DUT.
module tb_down_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int W     = 2*NREQ + 3 + WIDTH;

  logic                  CLK;
  logic                  CDN;
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] LDVAL;
  logic                  EN;
  logic [NREQ-1:0]       GNT;
  logic                  BUSY;
  logic [WIDTH-1:0]      CNT;
  logic                  TC;
  logic [NREQ-1:0]       DONE;
  logic                  ABRT;

  down_counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .CDN(CDN), .REQ(REQ), .LDVAL(LDVAL), .EN(EN),
    .GNT(GNT), .BUSY(BUSY), .CNT(CNT), .TC(TC), .DONE(DONE), .ABRT(ABRT)
  );

  // clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: one entry per step (expected outputs, drive values)
  logic [W-1:0]          exp_q[$];
  logic [W-1:0]          act_q[$];
  bit                    ck_q[$];
  logic [NREQ-1:0]       dq_req[$];
  logic                  dq_en[$];
  logic                  dq_cdn[$];
  logic [NREQ*WIDTH-1:0] dq_ld[$];

  // reference model state
  int               last_g;
  logic [WIDTH-1:0] prev_cnt;

  function automatic logic [W-1:0] pack(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                                        input logic a, input logic b, input logic t,
                                        input logic [WIDTH-1:0] c);
    return {g, d, a, b, t, c};
  endfunction

  function automatic string fmt(input logic [W-1:0] w);
    return $sformatf("gnt=%b done=%b abrt=%b busy=%b tc=%b cnt=%0d",
                     w[W-1 -: NREQ], w[W-1-NREQ -: NREQ], w[WIDTH+2], w[WIDTH+1], w[WIDTH],
                     w[WIDTH-1:0]);
  endfunction

  function automatic int next_grant(input int last, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_ld();
    logic [NREQ*WIDTH-1:0] l;
    for (int i = 0; i < NREQ; i++) l[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 20));
    return l;
  endfunction

  function automatic logic pick_en(input int mode, input int k);
    if (mode >= 100 || k > 60) return 1'b1;
    if (mode < 0) return (k % 2) == 0;
    return $urandom_range(0, 99) < mode;
  endfunction

  // driver tasks
  task automatic clear_sched();
    exp_q.delete(); act_q.delete(); ck_q.delete();
    dq_req.delete(); dq_en.delete(); dq_cdn.delete(); dq_ld.delete();
  endtask

  task automatic sched(input logic [NREQ-1:0] r, input logic e, input logic c,
                       input logic [NREQ*WIDTH-1:0] l, input bit k, input logic [W-1:0] x);
    dq_req.push_back(r); dq_en.push_back(e); dq_cdn.push_back(c);
    dq_ld.push_back(l); ck_q.push_back(k); exp_q.push_back(x);
  endtask

  task automatic run_sched();
    act_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      act_q.push_back(pack(GNT, DONE, ABRT, BUSY, TC, CNT));
      REQ   = dq_req[i];
      EN    = dq_en[i];
      CDN   = dq_cdn[i];
      LDVAL = dq_ld[i];
      @(posedge CLK);
      #1;
    end
  endtask

  // model: one full operation with EN held high (grant step .. DONE step)
  task automatic push_op(input int g, input int v, input logic [NREQ-1:0] r,
                         input logic [NREQ*WIDTH-1:0] l);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << g;
    sched(r, 1'b1, 1'b1, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, 1'b0, prev_cnt));
    for (int c = v; c >= 0; c--)
      sched(r, 1'b1, 1'b1, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, c == 0, WIDTH'(c)));
    sched(r, 1'b1, 1'b1, l, 1'b1, pack(oh, oh, 1'b0, 1'b1, 1'b0, '0));
    prev_cnt = '0;
    last_g   = g;
  endtask

  task automatic push_idle(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] l);
    sched(r, 1'b1, 1'b1, l, 1'b1, pack('0, '0, 1'b0, 1'b0, 1'b0, prev_cnt));
  endtask

  // model: single requester g, load v, EN pattern by mode, optional withdrawal at step abort_at
  task automatic plan_op(input int g, input int v, input int mode, input int abort_at, input bit noisy);
    logic [NREQ-1:0]       oh, nz;
    logic [NREQ*WIDTH-1:0] l;
    logic [W-1:0]          x;
    logic                  e;
    int                    seen, c, k;
    bit                    fin, aborted;
    oh = NREQ'(1) << g;
    l  = rand_ld();
    l[g*WIDTH +: WIDTH] = WIDTH'(v);
    sched(oh, 1'b0, 1'b1, l, 1'b0, '0);
    last_g  = g;
    seen    = 0;
    k       = 1;
    fin     = 0;
    aborted = 0;
    while (!fin) begin
      c  = (k == 1) ? int'(prev_cnt) : v - seen;
      x  = pack(oh, '0, 1'b0, 1'b1, (k >= 2) && (c == 0), WIDTH'(c));
      e  = pick_en(mode, k);
      nz = noisy ? (NREQ'($urandom) & ~oh) : '0;
      if (k == abort_at) begin
        sched('0, e, 1'b1, l, 1'b1, x);
        sched('0, 1'b0, 1'b1, l, 1'b1, pack('0, '0, 1'b1, 1'b0, 1'b0, WIDTH'(c)));
        sched('0, 1'b0, 1'b1, l, 1'b1, pack('0, '0, 1'b0, 1'b0, 1'b0, WIDTH'(c)));
        prev_cnt = WIDTH'(c);
        aborted  = 1;
        fin      = 1;
      end else begin
        sched(oh | nz, e, 1'b1, l, 1'b1, x);
        if (k >= 2 && c == 0) fin = 1;
        if (k >= 2 && e) seen++;
        k++;
      end
    end
    if (!aborted) begin
      sched('0, 1'b0, 1'b1, l, 1'b1, pack(oh, oh, 1'b0, 1'b1, 1'b0, '0));
      sched('0, 1'b0, 1'b1, l, 1'b1, pack('0, '0, 1'b0, 1'b0, 1'b0, '0));
      prev_cnt = '0;
    end
  endtask

  task automatic test_reset();
    logic [NREQ*WIDTH-1:0] l;
    logic [NREQ-1:0]       all, oh;
    clear_sched();
    l   = rand_ld();
    all = '1;
    last_g = NREQ - 1;
    oh  = NREQ'(1) << next_grant(last_g, all);
    sched(all, 1'b0, 1'b0, l, 1'b0, '0);
    sched(all, 1'b0, 1'b0, l, 1'b1, '0);
    sched(all, 1'b0, 1'b1, l, 1'b1, '0);
    sched(all, 1'b0, 1'b0, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, 1'b0, '0));
    sched('0,  1'b0, 1'b1, l, 1'b1, '0);
    sched('0,  1'b0, 1'b1, l, 1'b1, '0);
    run_sched();
    prev_cnt = '0;
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL reset step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_round_robin(input string name, input logic [NREQ-1:0] mask,
                                  input bit rand_vals, input int nops);
    logic [NREQ*WIDTH-1:0] l;
    int                    g, n;
    clear_sched();
    for (int i = 0; i < NREQ; i++) l[i*WIDTH +: WIDTH] = rand_vals ? WIDTH'($urandom_range(0, 5)) : WIDTH'(1);
    sched(mask, 1'b1, 1'b1, l, 1'b0, '0);
    for (int op = 0; op < nops; op++) begin
      g = next_grant(last_g, mask);
      push_op(g, int'(l[g*WIDTH +: WIDTH]), mask, l);
      push_idle(mask, l);
    end
    n = exp_q.size();
    dq_req[n-2] = '0;
    dq_req[n-1] = '0;
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s step %0d: got %s, expected %s", name, i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_single();
    clear_sched();
    plan_op(2, 5, 100, -1, 1'b0);
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL single step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_stall_zero();
    clear_sched();
    plan_op(0, 3, -1, -1, 1'b0);
    plan_op(1, 0, 100, -1, 1'b1);
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_zero step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_abort_reset();
    logic [NREQ*WIDTH-1:0] l;
    logic [NREQ-1:0]       oh;
    clear_sched();
    plan_op(1, 5, 100, 5, 1'b0);
    plan_op(3, 4, 100, 1, 1'b1);
    l  = rand_ld();
    l[1*WIDTH +: WIDTH] = WIDTH'(6);
    oh = NREQ'(1) << 1;
    sched(oh, 1'b1, 1'b1, l, 1'b0, '0);
    sched(oh, 1'b1, 1'b1, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, 1'b0, prev_cnt));
    sched(oh, 1'b1, 1'b1, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, 1'b0, WIDTH'(6)));
    sched('0, 1'b1, 1'b0, l, 1'b1, pack(oh, '0, 1'b0, 1'b1, 1'b0, WIDTH'(5)));
    sched('0, 1'b1, 1'b1, l, 1'b1, '0);
    sched('0, 1'b1, 1'b1, l, 1'b1, '0);
    sched('0, 1'b1, 1'b1, l, 1'b1, '0);
    last_g   = NREQ - 1;
    prev_cnt = '0;
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL abort_reset step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_periodic();
    logic [NREQ*WIDTH-1:0] l;
    int                    raise_at, d2, d3;
    clear_sched();
    l = rand_ld();
    l[3*WIDTH +: WIDTH] = WIDTH'(2);
    l[0*WIDTH +: WIDTH] = WIDTH'(1);
    sched(4'b1000, 1'b1, 1'b1, l, 1'b0, '0);
    push_op(3, 2, 4'b1000, l);
`ifndef DCA_AUTORELOAD_EN
    push_idle(4'b1000, l);
`endif
    raise_at = exp_q.size() + 1;
    push_op(3, 2, 4'b1000, l);
    d2 = exp_q.size() - 1;
    push_idle(4'b0001, l);
    push_op(next_grant(last_g, 4'b0001), 1, 4'b0001, l);
    d3 = exp_q.size() - 1;
    push_idle('0, l);
    for (int i = raise_at; i < exp_q.size(); i++)
      dq_req[i] = (i < d2) ? 4'b1001 : (i < d3) ? 4'b0001 : 4'b0000;
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL periodic step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    int g, v, mode, ab;
    clear_sched();
    for (int op = 0; op < 30; op++) begin
      g    = $urandom_range(0, NREQ - 1);
      v    = $urandom_range(0, 10);
      mode = ($urandom_range(0, 1) == 1) ? 100 : int'($urandom_range(40, 90));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, v + 2)) : -1;
      plan_op(g, v, mode, ab, $urandom_range(0, 1) == 1);
    end
    run_sched();
    foreach (exp_q[i]) begin
      if (ck_q[i]) begin
        n_checks++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random step %0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] m;
    CDN = 1'b0; REQ = '0; EN = 1'b0; LDVAL = '0;
    last_g = NREQ - 1; prev_cnt = '0;
    test_reset();
    test_round_robin("round_robin", 4'b1111, 1'b0, 5);
    test_single();
    test_stall_zero();
    test_abort_reset();
    test_periodic();
    test_random();
    do m = NREQ'($urandom); while ($countones(m) < 2);
    test_round_robin("rr_random", m, 1'b1, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
